// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder with oversampled pins, word-level rx strobe and one-word tx buffer.
// Optional: define SPI_SLAVE_MISO_TRISTATE_EN to release SPI_MISO (1'bz) while idle.  Rev 1.0
`default_nettype none

module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_CS,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txLoad,
  output logic                  txReady,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxValid,
  output logic                  frameErr,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s, sclk_d, cs_d;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic [DATA_WIDTH-2:0] tx_shift;
  logic                  miso_q;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  word_done;
  logic                  reload;
  logic [DATA_WIDTH-1:0] next_word;

  // CS synchronizer resets low so a CS already low at reset release produces no fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign rx_word   = {rx_shift, mosi_s};

  assign reload = ((state == IDLE) && cs_fall) ||
                  ((state == ACTIVE) && !cs_rise && sclk_fall && word_done);

  // Empty buffer with a simultaneous load feeds txData straight into the shifter.
  always_comb begin
    next_word = '0;
    if (!txReady)
      next_word = tx_buf;
    else if (txLoad)
      next_word = txData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_buf    <= '0;
      txReady   <= 1'b1;
      tx_shift  <= '0;
      miso_q    <= 1'b0;
      rx_shift  <= '0;
      rxData    <= '0;
      rxValid   <= 1'b0;
      frameErr  <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      rxValid  <= 1'b0;
      frameErr <= 1'b0;

      if (txLoad && txReady && !reload) begin
        tx_buf  <= txData;
        txReady <= 1'b0;
      end
      if (reload && !txReady)
        txReady <= 1'b1;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            tx_shift  <= next_word[DATA_WIDTH-2:0];
            miso_q    <= next_word[DATA_WIDTH-1];
            rx_shift  <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            miso_q    <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            if (bit_cnt != '0)
              frameErr <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift <= rx_word[DATA_WIDTH-2:0];
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              rxData    <= rx_word;
              rxValid   <= 1'b1;
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            if (word_done) begin
              tx_shift  <= next_word[DATA_WIDTH-2:0];
              miso_q    <= next_word[DATA_WIDTH-1];
              word_done <= 1'b0;
            end else begin
              miso_q   <= tx_shift[DATA_WIDTH-2];
              tx_shift <= tx_shift << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign SPI_MISO = (state == ACTIVE) ? miso_q : 1'bz;
`else
  assign SPI_MISO = miso_q;
`endif

endmodule

`default_nettype wire
